// File: rtl/arb8_rr_if.sv
// -----------------------------------------------------------------------------
// arb8_rr_if
// Request/grant bundle between eight requesters and the round-robin arbiter.
//
// Signals:
//   en       - global arbitration enable (gates new grants only)
//   req      - per-requester request, held high while ownership is wanted
//   gnt      - one-hot grant, 8'h00 when no grant is active
//   gnt_idx  - index of the current or last owner
//   gnt_vld  - a grant is active
//   timeout  - one-cycle pulse when a grant is forcibly revoked
//
// Modports:
//   master - requester side (drives en/req, observes the grant)
//   slave  - arbiter side (observes en/req, drives the grant)
// -----------------------------------------------------------------------------
interface arb8_rr_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_vld,
        input  timeout
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_vld,
        output timeout
    );
endinterface

// File: rtl/arb8_rr.sv
// -----------------------------------------------------------------------------
// arb8_rr
// Eight-way round-robin arbiter with a request/hold handshake. The winner's
// index is registered and decoded to a one-hot grant. After an owner releases,
// the priority pointer moves to the requester just past it, so a line that
// keeps requesting is served within seven intervening grants.
//
// Optional feature (compile-time macro ARB8_TIMEOUT_EN): hold-timeout
// watchdog that revokes a grant after MAX_HOLD consecutive cycles and pulses
// timeout for one cycle. With the macro undefined, grants last as long as
// the owner holds req and timeout is tied to 0.
//
// Parameters:
//   MAX_HOLD - maximum consecutive grant cycles per owner with the watchdog
//              compiled in (legal range 2..255)
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - arb8_rr_if.slave: en, req in; gnt, gnt_idx, gnt_vld, timeout out
// -----------------------------------------------------------------------------
module arb8_rr #(
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    arb8_rr_if.slave    bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_n;
    logic [2:0] ptr_q,   ptr_n;
    logic [2:0] idx_q,   idx_n;
    logic       vld_q,   vld_n;

    logic [2:0] sel_idx;
    logic       sel_found;
    logic       force_rel;

    // -------------------------------------------------------------------------
    // Rotating priority search: first set request at ptr, ptr+1, ... ptr+7.
    // The 3-bit add wraps naturally modulo 8.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven from always_comb gets a default before any
        // conditional assignment; a path that leaves it unassigned infers a latch.
        sel_idx   = 3'd0;
        sel_found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] cand;
            cand = ptr_q + 3'(i);
            if (!sel_found && bus.req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

`ifdef ARB8_TIMEOUT_EN
    // -------------------------------------------------------------------------
    // Hold watchdog. The counter is 0 on the first grant cycle, so reaching
    // MAX_HOLD-1 means the owner has held for MAX_HOLD cycles and the next
    // edge must release.
    // -------------------------------------------------------------------------
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_n;
    logic       timeout_q, timeout_n;

    assign force_rel = (state_q == GRANT) && bus.req[idx_q] && (hold_q == HOLD_LAST);

    always_comb begin
        hold_n    = hold_q;
        timeout_n = 1'b0;
        if (state_q == IDLE) begin
            hold_n = 8'd0;
        end else if (force_rel) begin
            timeout_n = 1'b1;
        end else if (bus.req[idx_q] && (hold_q != 8'hFF)) begin
            hold_n = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_n;
            timeout_q <= timeout_n;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign force_rel   = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic. en only gates the IDLE->GRANT transition; once granted,
    // only the owner's req (or the watchdog) ends the grant.
    // -------------------------------------------------------------------------
    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        idx_n   = idx_q;
        vld_n   = vld_q;
        case (state_q)
            IDLE: begin
                if (bus.en && sel_found) begin
                    state_n = GRANT;
                    idx_n   = sel_idx;
                    vld_n   = 1'b1;
                end
            end
            GRANT: begin
                if (!bus.req[idx_q] || force_rel) begin
                    state_n = IDLE;
                    vld_n   = 1'b0;
                    ptr_n   = idx_q + 3'd1;
                end
            end
            default: begin
                state_n = IDLE;
                vld_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            idx_q   <= 3'd0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            idx_q   <= idx_n;
            vld_q   <= vld_n;
        end
    end

    // Pure decode of registered state: glitch-free and at most one bit set.
    assign bus.gnt     = vld_q ? (8'b1 << idx_q) : 8'h00;
    assign bus.gnt_idx = idx_q;
    assign bus.gnt_vld = vld_q;

endmodule

// File: tb/tb_arb8_rr.sv
// -----------------------------------------------------------------------------
// tb_arb8_rr
// Self-checking bench for arb8_rr: a table of hand-derived vectors, directed
// multi-cycle sequences, and a randomized phase. Every cycle is also compared
// against a behavioural model that tracks owner, pointer and hold length with
// plain integers.
// -----------------------------------------------------------------------------
module tb_arb8_rr;

    localparam int MAX_HOLD = 4;
`ifdef ARB8_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    arb8_rr_if bus ();

    arb8_rr #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural reference model ----------------
    bit m_valid;
    int m_idx;
    int m_ptr;
    int m_held;   // number of grant cycles the current owner has had
    bit m_to;

    task automatic model_step(input bit r_n, input bit e, input logic [7:0] rq);
        if (!r_n) begin
            m_valid = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (!m_valid) begin
                if (e && rq != 8'h00) begin
                    for (int k = 0; k < 8; k++) begin
                        int c;
                        c = (m_ptr + k) % 8;
                        if (rq[c]) begin
                            m_idx = c; m_valid = 1; m_held = 1;
                            break;
                        end
                    end
                end
            end else if (!rq[m_idx]) begin
                m_valid = 0; m_ptr = (m_idx + 1) % 8;
            end else if (TO_EN && m_held == MAX_HOLD) begin
                m_valid = 0; m_ptr = (m_idx + 1) % 8; m_to = 1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge: update the model with the inputs seen at the edge,
    // then compare all outputs shortly after the edge.
    task automatic tick();
        logic [7:0] exp_gnt;
        @(posedge clk);
        model_step(rst_n, bus.en, bus.req);
        #1;
        exp_gnt = m_valid ? (8'h01 << m_idx) : 8'h00;
        check("model_gnt",     32'(bus.gnt),     32'(exp_gnt));
        check("model_gnt_idx", 32'(bus.gnt_idx), 32'(m_idx));
        check("model_gnt_vld", 32'(bus.gnt_vld), 32'(m_valid));
        check("model_timeout", 32'(bus.timeout), 32'(m_to));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bus.en = 1'b1; bus.req = 8'hFF;
        tick(); tick();
        rst_n = 1'b1; bus.req = 8'h00;
    endtask

    typedef struct {
        bit         rst_n;
        bit         en;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        bit         vld;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [7:0] r;
        rst_n   = 1'b0;
        bus.en  = 1'b0;
        bus.req = 8'h00;

        // ---------------- table-driven vectors (from reset) ----------------
        vecs[0]  = '{0, 1, 8'hFF, 8'h00, 3'd0, 0};
        vecs[1]  = '{0, 1, 8'hFF, 8'h00, 3'd0, 0};
        vecs[2]  = '{1, 1, 8'h08, 8'h08, 3'd3, 1};
        vecs[3]  = '{1, 1, 8'h08, 8'h08, 3'd3, 1};
        vecs[4]  = '{1, 1, 8'h00, 8'h00, 3'd3, 0};
        vecs[5]  = '{1, 0, 8'hFF, 8'h00, 3'd3, 0};
        vecs[6]  = '{1, 0, 8'hFF, 8'h00, 3'd3, 0};
        vecs[7]  = '{1, 1, 8'h11, 8'h10, 3'd4, 1};
        vecs[8]  = '{1, 0, 8'h11, 8'h10, 3'd4, 1};
        vecs[9]  = '{1, 1, 8'h01, 8'h00, 3'd4, 0};
        vecs[10] = '{1, 1, 8'h01, 8'h01, 3'd0, 1};
        vecs[11] = '{1, 1, 8'h00, 8'h00, 3'd0, 0};
        vecs[12] = '{1, 1, 8'h80, 8'h80, 3'd7, 1};
        vecs[13] = '{1, 1, 8'h00, 8'h00, 3'd7, 0};

        for (int i = 0; i < 14; i++) begin
            rst_n = vecs[i].rst_n; bus.en = vecs[i].en; bus.req = vecs[i].req;
            tick();
            check($sformatf("vec%0d_gnt", i),     32'(bus.gnt),     32'(vecs[i].gnt));
            check($sformatf("vec%0d_idx", i),     32'(bus.gnt_idx), 32'(vecs[i].idx));
            check($sformatf("vec%0d_vld", i),     32'(bus.gnt_vld), 32'(vecs[i].vld));
            check($sformatf("vec%0d_timeout", i), 32'(bus.timeout), 32'(0));
        end

        // ---------------- rotation with one-cycle gaps ----------------
        do_reset();
        for (int k = 0; k < 9; k++) begin
            r = 8'hFF;
            bus.req = r;
            tick();
            check($sformatf("rot%0d_gnt_a", k), 32'(bus.gnt), 32'(8'h01 << (k % 8)));
            tick();
            check($sformatf("rot%0d_gnt_b", k), 32'(bus.gnt), 32'(8'h01 << (k % 8)));
            r[k % 8] = 1'b0;
            bus.req = r;
            tick();
            check($sformatf("rot%0d_gap", k), 32'(bus.gnt), 32'(0));
        end

        // ---------------- wrap from ptr=7 ----------------
        do_reset();
        bus.req = 8'h40; tick();
        check("wrap_own6", 32'(bus.gnt), 32'(8'h40));
        bus.req = 8'h00; tick();
        bus.req = 8'h81; tick();
        check("wrap_gnt7", 32'(bus.gnt), 32'(8'h80));
        bus.req = 8'h01; tick();
        check("wrap_gap", 32'(bus.gnt), 32'(8'h00));
        tick();
        check("wrap_gnt0", 32'(bus.gnt), 32'(8'h01));
        bus.req = 8'h00; tick();

        // ---------------- active grant survives en falling ----------------
        bus.req = 8'h04; tick();
        bus.en = 1'b0; bus.req = 8'hFF; tick();
        check("en_hold_gnt", 32'(bus.gnt), 32'(8'h04));
        bus.req = 8'hFB; tick();
        check("en_release", 32'(bus.gnt), 32'(8'h00));
        tick(); tick();
        check("en_blocked", 32'(bus.gnt), 32'(8'h00));
        bus.en = 1'b1; tick();
        check("en_regrant3", 32'(bus.gnt), 32'(8'h08));

        // ---------------- hold timeout ----------------
        do_reset();
        bus.req = 8'h03;
        for (int c = 0; c < MAX_HOLD; c++) begin
            tick();
            check($sformatf("to_hold%0d", c), 32'(bus.gnt), 32'(8'h01));
            check($sformatf("to_quiet%0d", c), 32'(bus.timeout), 32'(0));
        end
        tick();
        if (TO_EN) begin
            check("to_revoke_gnt", 32'(bus.gnt), 32'(8'h00));
            check("to_pulse", 32'(bus.timeout), 32'(1));
            tick();
            check("to_next_owner", 32'(bus.gnt), 32'(8'h02));
            check("to_pulse_end", 32'(bus.timeout), 32'(0));
        end else begin
            for (int c = 0; c < 6; c++) begin
                check($sformatf("nto_hold%0d", c), 32'(bus.gnt), 32'(8'h01));
                check($sformatf("nto_quiet%0d", c), 32'(bus.timeout), 32'(0));
                tick();
            end
        end

        // ---------------- mid-grant reset ----------------
        do_reset();
        bus.req = 8'h20; tick();
        check("mrst_gnt5", 32'(bus.gnt), 32'(8'h20));
        rst_n = 1'b0; tick();
        check("mrst_drop", 32'(bus.gnt), 32'(8'h00));
        check("mrst_idx", 32'(bus.gnt_idx), 32'(0));
        rst_n = 1'b1; bus.req = 8'h21; tick();
        check("mrst_ptr0", 32'(bus.gnt), 32'(8'h01));

        // ---------------- randomized phase ----------------
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) bus.req = 8'($urandom);
            bus.en = ($urandom_range(7) != 0);
            rst_n  = ($urandom_range(299) != 0);
            tick();
            check("onehot", 32'($countones(bus.gnt) <= 1), 32'(1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
